// File: rtl/hs32_mem_arbiter_pkg.sv
// rtl/hs32_mem_arbiter_pkg.sv - shared state/grant encodings for the hs32 memory arbiter
package hs32_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] ARB_G_NONE = 2'b00;
    localparam logic [1:0] ARB_G_X    = 2'b01;
    localparam logic [1:0] ARB_G_F    = 2'b10;

    // Fetch takes the bus when it is the only requester or when exec has starved it.
    function automatic logic fetch_wins(input logic x_req, input logic f_req, input logic starved);
        return f_req && (!x_req || starved);
    endfunction

endpackage

// File: rtl/hs32_mem_arbiter_if.sv
// rtl/hs32_mem_arbiter_if.sv - exec/fetch requester and downstream memory bus bundle
interface hs32_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          x_req;
    logic          x_rw;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_dtw;
    logic [DW-1:0] x_dtr;
    logic          x_rdy;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_dtr;
    logic          f_rdy;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dtw;
    logic [DW-1:0] mem_dtr;
    logic          mem_req;
    logic          mem_rw;
    logic          mem_rdy;

    logic [1:0]    grant;
    logic          err;

    // Arbiter side: owns the memory bus and the completion outputs.
    modport master (
        input  x_req, x_rw, x_addr, x_dtw, f_req, f_addr, mem_dtr, mem_rdy,
        output x_dtr, x_rdy, f_dtr, f_rdy, mem_addr, mem_dtw, mem_req, mem_rw, grant, err
    );

    // Environment side: requesters plus the memory/MMIO responder.
    modport slave (
        output x_req, x_rw, x_addr, x_dtw, f_req, f_addr, mem_dtr, mem_rdy,
        input  x_dtr, x_rdy, f_dtr, f_rdy, mem_addr, mem_dtw, mem_req, mem_rw, grant, err
    );

endinterface

// File: rtl/hs32_arb_timer.sv
// rtl/hs32_arb_timer.sv - loadable saturating counter with clear, enable and terminal count
module hs32_arb_timer #(
    parameter int MAX = 255,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear beats load beats count; the count holds once it reaches MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(MAX));

endmodule

// File: rtl/hs32_mem_arbiter.sv
// rtl/hs32_mem_arbiter.sv - exec/fetch memory bus arbiter; BUSY timeout under HS32_ARB_TIMEOUT_EN
module hs32_mem_arbiter
    import hs32_mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset,
    hs32_mem_arbiter_if.master bus
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_e    state_q,    state_d;
    logic [1:0]    grant_q,    grant_d;
    logic [SW-1:0] starve_q,   starve_d;
    logic          mem_req_q,  mem_req_d;
    logic          mem_rw_q,   mem_rw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_dtw_q,  mem_dtw_d;
    logic          x_rdy_q,    x_rdy_d;
    logic          f_rdy_q,    f_rdy_d;
    logic [DW-1:0] x_dtr_q,    x_dtr_d;
    logic [DW-1:0] f_dtr_q,    f_dtr_d;

`ifdef HS32_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic err_q, err_d;
    logic tmr_clr, tmr_load, tmr_en, tmr_tc;

    // The timer is loaded with 1 on BUSY entry so that tc marks the TIMEOUT-th BUSY cycle.
    hs32_arb_timer #(
        .MAX (TIMEOUT),
        .W   (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (TW'(1)),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );
`endif

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        starve_d   = starve_q;
        mem_req_d  = mem_req_q;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_dtw_d  = mem_dtw_q;
        x_rdy_d    = 1'b0;
        f_rdy_d    = 1'b0;
        x_dtr_d    = x_dtr_q;
        f_dtr_d    = f_dtr_q;
`ifdef HS32_ARB_TIMEOUT_EN
        err_d      = 1'b0;
        tmr_clr    = (state_q == ARB_DONE);
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.x_req || bus.f_req) begin
                    if (fetch_wins(bus.x_req, bus.f_req, starve_q == SW'(STARVE_MAX))) begin
                        grant_d    = ARB_G_F;
                        mem_addr_d = bus.f_addr;
                        mem_dtw_d  = '0;
                        mem_rw_d   = 1'b0;
                        starve_d   = '0;
                    end else begin
                        grant_d    = ARB_G_X;
                        mem_addr_d = bus.x_addr;
                        mem_dtw_d  = bus.x_dtw;
                        mem_rw_d   = bus.x_rw;
                        if (!bus.f_req) begin
                            starve_d = '0;
                        end else if (starve_q != SW'(STARVE_MAX)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                    mem_req_d = 1'b1;
                    state_d   = ARB_BUSY;
`ifdef HS32_ARB_TIMEOUT_EN
                    tmr_load  = 1'b1;
`endif
                end
            end
            ARB_BUSY: begin
                // A completion in the timeout cycle still counts as a normal completion.
                if (mem_req_q && bus.mem_rdy) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_DONE;
                    if (grant_q == ARB_G_F) begin
                        f_rdy_d = 1'b1;
                        f_dtr_d = bus.mem_dtr;
                    end else begin
                        x_rdy_d = 1'b1;
                        if (!mem_rw_q) begin
                            x_dtr_d = bus.mem_dtr;
                        end
                    end
`ifdef HS32_ARB_TIMEOUT_EN
                end else if (tmr_tc) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_DONE;
                    err_d     = 1'b1;
                    if (grant_q == ARB_G_F) begin
                        f_rdy_d = 1'b1;
                        f_dtr_d = '0;
                    end else begin
                        x_rdy_d = 1'b1;
                        x_dtr_d = '0;
                    end
                end else begin
                    tmr_en = 1'b1;
`endif
                end
            end
            ARB_DONE: begin
                grant_d = ARB_G_NONE;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // All state and outputs are registered and cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= ARB_G_NONE;
            starve_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dtw_q  <= '0;
            x_rdy_q    <= 1'b0;
            f_rdy_q    <= 1'b0;
            x_dtr_q    <= '0;
            f_dtr_q    <= '0;
`ifdef HS32_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            starve_q   <= starve_d;
            mem_req_q  <= mem_req_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_dtw_q  <= mem_dtw_d;
            x_rdy_q    <= x_rdy_d;
            f_rdy_q    <= f_rdy_d;
            x_dtr_q    <= x_dtr_d;
            f_dtr_q    <= f_dtr_d;
`ifdef HS32_ARB_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_rw   = mem_rw_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dtw  = mem_dtw_q;
    assign bus.x_rdy    = x_rdy_q;
    assign bus.f_rdy    = f_rdy_q;
    assign bus.x_dtr    = x_dtr_q;
    assign bus.f_dtr    = f_dtr_q;
`ifdef HS32_ARB_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// tb/tb_hs32_mem_arbiter.sv - self-checking bench for hs32_mem_arbiter
module tb_hs32_mem_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;
    localparam logic [1:0] GX = 2'b01;
    localparam logic [1:0] GF = 2'b10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hs32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    hs32_mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          fetch;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] dtw;
        int          wt;
        logic [31:0] exp_dtr;
        logic [1:0]  exp_grant;
        logic [31:0] exp_dtw;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // memory responder state
    logic [31:0] mem_model [logic [31:0]];
    int mem_cnt   = 0;
    int mem_wait  = 0;
    bit mem_hang  = 0;
    bit rand_wait = 0;
    bit junk_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: answers a request after mem_wait idle cycles unless hung.
    task automatic mem_step();
        if (bus.mem_req) begin
            if (mem_cnt == 0 && rand_wait) mem_wait = $urandom_range(0, 3);
            if (!mem_hang && mem_cnt == mem_wait) begin
                bus.mem_rdy = 1'b1;
                bus.mem_dtr = mem_read(bus.mem_addr);
                if (bus.mem_rw) mem_model[bus.mem_addr] = bus.mem_dtw;
            end else begin
                bus.mem_rdy = 1'b0;
                bus.mem_dtr = $urandom;
            end
            mem_cnt++;
        end else begin
            mem_cnt = 0;
            bus.mem_rdy = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_dtr = $urandom;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic do_reset();
        bus.x_req = 1'b0;
        bus.f_req = 1'b0;
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    // One isolated transaction: latency, bus stability, single rdy pulse, data hold.
    task automatic run_vec(input vec_t v, input string tag);
        int busy;
        bit done;
        busy = 0;
        done = 0;
        if (v.fetch) begin
            bus.f_addr = v.addr;
            bus.f_req  = 1'b1;
        end else begin
            bus.x_addr = v.addr;
            bus.x_rw   = v.rw;
            bus.x_dtw  = v.dtw;
            bus.x_req  = 1'b1;
        end
        mem_wait = v.wt;
        cycle();
        chk({tag, " mem_req_latency"}, bus.mem_req, 1);
        chk({tag, " grant"}, bus.grant, v.exp_grant);
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_req) begin
                done = 1;
                break;
            end
            busy++;
            chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
            chk({tag, " mem_rw"}, bus.mem_rw, v.rw);
            chk({tag, " mem_dtw"}, bus.mem_dtw, v.exp_dtw);
            chk({tag, " early_rdy"}, {bus.x_rdy, bus.f_rdy}, 0);
            cycle();
        end
        chk({tag, " completed"}, done, 1);
        chk({tag, " busy_cycles"}, busy, v.wt + 1);
        chk({tag, " x_rdy"}, bus.x_rdy, !v.fetch);
        chk({tag, " f_rdy"}, bus.f_rdy, v.fetch);
        chk({tag, " err"}, bus.err, 0);
        chk({tag, " grant_hold"}, bus.grant, v.exp_grant);
        chk({tag, " dtr"}, v.fetch ? bus.f_dtr : bus.x_dtr, v.exp_dtr);
        if (v.fetch) bus.f_req = 1'b0;
        else bus.x_req = 1'b0;
        cycle();
        chk({tag, " rdy_one_cycle"}, {bus.x_rdy, bus.f_rdy}, 0);
        chk({tag, " grant_release"}, bus.grant, 0);
        chk({tag, " dtr_hold"}, v.fetch ? bus.f_dtr : bus.x_dtr, v.exp_dtr);
    endtask

    vec_t vecs[8];
    vec_t rv;

    // random-phase reference model state
    logic [1:0]  p_grant, e_grant, own;
    bit          p_mreq, e_mreq, e_xr, e_fr;
    bit          p_xr, p_fr, p_xw, p_mrdy;
    logic [31:0] p_xa, p_xd, p_fa, p_mdtr;
    logic [31:0] t_addr, t_dtw, ex_xdtr, ex_fdtr;
    bit          t_rw;
    int          starve;
    int          ng, s_model, busy_n, hi_n, err_n;
    logic [1:0]  prevg, exp_g;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.x_req = 0; bus.x_rw = 0; bus.x_addr = '0; bus.x_dtw = '0;
        bus.f_req = 0; bus.f_addr = '0;
        bus.mem_rdy = 0; bus.mem_dtr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset grant", bus.grant, 0);
        chk("reset mem_req", bus.mem_req, 0);
        chk("reset rdys", {bus.x_rdy, bus.f_rdy}, 0);
        chk("reset err", bus.err, 0);
        chk("reset x_dtr", bus.x_dtr, 0);
        chk("reset f_dtr", bus.f_dtr, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        reset = 1'b1;
        cycle();

        // directed table
        mem_model[32'h100] = 32'hDEADBEEF;
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        0, 32'hDEADBEEF, GX, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h200, 32'h12345678, 3, 32'hDEADBEEF, GX, 32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 32'h200, 32'hAAAA5555, 1, 32'h12345678, GX, 32'hAAAA5555};
        vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,        0, 32'h5A5A0C0F, GF, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h200, 32'h0,        2, 32'h12345678, GF, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 0, 32'h12345678, GX, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'h100, 32'h0,        0, 32'hCAFEF00D, GF, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h300, 32'h0,        7, 32'h5A5A0C0F, GF, 32'h0};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // starvation: both requesters hold req continuously
        do_reset();
        mem_wait = 0;
        bus.x_addr = 32'h600; bus.x_rw = 1'b0; bus.f_addr = 32'h700;
        bus.x_req = 1'b1; bus.f_req = 1'b1;
        ng = 0; s_model = 0; prevg = 2'b00;
        for (int i = 0; i < 200 && ng < 10; i++) begin
            cycle();
            if (bus.x_rdy || bus.f_rdy) chk("starve rdy_overlap", bus.x_rdy & bus.f_rdy, 0);
            if (prevg == 2'b00 && bus.grant != 2'b00) begin
                exp_g = (s_model == STARVE_MAX) ? GF : GX;
                s_model = (s_model == STARVE_MAX) ? 0 : s_model + 1;
                chk($sformatf("starve grant%0d", ng), bus.grant, exp_g);
                ng++;
            end
            prevg = bus.grant;
        end
        chk("starve grant_count", ng, 10);
        bus.x_req = 1'b0; bus.f_req = 1'b0;
        repeat (4) cycle();

        // asynchronous reset in BUSY
        mem_hang = 1;
        bus.f_addr = 32'h400; bus.f_req = 1'b1;
        cycle(); cycle(); cycle();
        chk("rst pre busy", bus.mem_req, 1);
        reset = 1'b0;
        #1;
        chk("rst async mem_req", bus.mem_req, 0);
        chk("rst async grant", bus.grant, 0);
        chk("rst async rdys", {bus.x_rdy, bus.f_rdy}, 0);
        bus.f_req = 1'b0; mem_hang = 0;
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst no_rdy", {bus.x_rdy, bus.f_rdy, bus.mem_req}, 0);
        rv = '{1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h5A5A0A0F, GF, 32'h0};
        run_vec(rv, "post_rst");

        // randomized traffic against a transaction-level model
        do_reset();
        rand_wait = 1; junk_en = 1;
        p_grant = 2'b00; p_mreq = 0; own = 2'b00; starve = 0;
        ex_xdtr = '0; ex_fdtr = '0; t_addr = '0; t_dtw = '0; t_rw = 0;
        for (int c = 0; c < 3000; c++) begin
            p_xr = bus.x_req; p_fr = bus.f_req; p_xw = bus.x_rw;
            p_xa = bus.x_addr; p_xd = bus.x_dtw; p_fa = bus.f_addr;
            p_mrdy = bus.mem_rdy; p_mdtr = bus.mem_dtr;
            cycle();
            e_xr = 0; e_fr = 0;
            if (p_grant == 2'b00) begin
                if (p_xr || p_fr) begin
                    if (p_fr && (!p_xr || starve == STARVE_MAX)) begin
                        own = GF; t_addr = p_fa; t_rw = 0; t_dtw = '0; starve = 0;
                    end else begin
                        own = GX; t_addr = p_xa; t_rw = p_xw; t_dtw = p_xd;
                        if (!p_fr) starve = 0;
                        else if (starve < STARVE_MAX) starve++;
                    end
                    e_grant = own; e_mreq = 1;
                end else begin
                    e_grant = 2'b00; e_mreq = 0;
                end
            end else if (p_mreq) begin
                e_grant = own;
                if (p_mrdy) begin
                    e_mreq = 0; e_xr = own[0]; e_fr = own[1];
                    if (own[1]) ex_fdtr = p_mdtr;
                    else if (!t_rw) ex_xdtr = p_mdtr;
                end else begin
                    e_mreq = 1;
                end
            end else begin
                e_grant = 2'b00; e_mreq = 0;
            end
            chk("rand grant", bus.grant, e_grant);
            chk("rand mem_req", bus.mem_req, e_mreq);
            chk("rand rdys", {bus.x_rdy, bus.f_rdy}, {e_xr, e_fr});
            chk("rand x_dtr", bus.x_dtr, ex_xdtr);
            chk("rand f_dtr", bus.f_dtr, ex_fdtr);
            chk("rand err", bus.err, 0);
            if (e_mreq) chk("rand mem_bus", {bus.mem_rw, bus.mem_addr, bus.mem_dtw}, {t_rw, t_addr, t_dtw});
            p_grant = e_grant; p_mreq = e_mreq;
            if (bus.x_req) begin
                if (e_xr) begin
                    if ($urandom_range(0, 1) == 0) bus.x_req = 1'b0;
                    else begin
                        bus.x_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                        bus.x_rw = 1'($urandom_range(0, 1)); bus.x_dtw = $urandom;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.x_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                bus.x_rw = 1'($urandom_range(0, 1)); bus.x_dtw = $urandom;
                bus.x_req = 1'b1;
            end
            if (bus.f_req) begin
                if (e_fr) begin
                    if ($urandom_range(0, 1) == 0) bus.f_req = 1'b0;
                    else bus.f_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.f_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                bus.f_req = 1'b1;
            end
        end

        // hung memory: timeout abort, or an indefinite wait without the feature
        do_reset();
        rand_wait = 0; junk_en = 0;
        rv = '{1'b1, 1'b0, 32'h900, 32'h0, 0, 32'h5A5A060F, GF, 32'h0};
        run_vec(rv, "pre_hang");
        mem_hang = 1;
        bus.f_addr = 32'h800; bus.f_req = 1'b1;
        cycle();
        chk("hang mem_req", bus.mem_req, 1);
`ifdef HS32_ARB_TIMEOUT_EN
        busy_n = 0;
        for (int i = 0; i < 50; i++) begin
            if (!bus.mem_req) break;
            busy_n++;
            chk("tmo err_early", bus.err, 0);
            cycle();
        end
        chk("tmo busy_cycles", busy_n, TIMEOUT);
        chk("tmo err", bus.err, 1);
        chk("tmo f_rdy", bus.f_rdy, 1);
        chk("tmo x_rdy", bus.x_rdy, 0);
        chk("tmo f_dtr", bus.f_dtr, 0);
        chk("tmo mem_req", bus.mem_req, 0);
        bus.f_req = 1'b0;
        cycle();
        chk("tmo err_pulse", {bus.err, bus.f_rdy}, 0);
        chk("tmo grant_release", bus.grant, 0);
`else
        hi_n = 0; err_n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.mem_req && bus.grant == GF && !bus.f_rdy) hi_n++;
            if (bus.err) err_n++;
            cycle();
        end
        chk("hang busy_held", hi_n, 1000);
        chk("hang err_low", err_n, 0);
`endif
        mem_hang = 0;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
